// File: rtl/adc_avg_sequencer.sv
// Runs a settle delay then 2^k driver conversions per cs pulse and reports the truncated mean.
// All outputs are registered; timeouts in either handshake phase abort with err set and rdy returned.
module adc_avg_sequencer #(
    parameter int DATA_W        = 14,
    parameter int MAX_LOG2      = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [2:0]        avg_log2,
    output logic              rdy,
    output logic [DATA_W-1:0] adc_out,
    output logic              err,
    output logic              drv_cs,
    input  logic              drv_rdy,
    input  logic [DATA_W-1:0] drv_data
);

    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] K_MAX        = 3'(MAX_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_CHECK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        kq_q, kq_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] adc_q, adc_d;
    logic              err_q, err_d;
    logic              drv_cs_q, drv_cs_d;

    always_comb begin
        state_d  = state_q;
        kq_d     = kq_q;
        acc_d    = acc_q;
        scnt_d   = scnt_q;
        tcnt_d   = tcnt_q;
        rdy_d    = rdy_q;
        adc_d    = adc_q;
        err_d    = err_q;
        drv_cs_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    kq_d    = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
                    acc_d   = '0;
                    scnt_d  = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // drv_cs is registered, so it is raised on the edge that enters START
                if (tcnt_q == SETTLE_LAST) begin
                    tcnt_d   = '0;
                    drv_cs_d = 1'b1;
                    state_d  = S_START;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!drv_rdy) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT_HI;
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_WAIT_HI: begin
                if (drv_rdy) begin
                    acc_d   = acc_q + ACC_W'(drv_data);
                    scnt_d  = scnt_q + CNT_W'(1);
                    state_d = S_CHECK;
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (scnt_q == (CNT_W'(1) << kq_q)) begin
                    state_d = S_DONE;
                end else begin
                    drv_cs_d = 1'b1;
                    state_d  = S_START;
                end
            end
            S_DONE: begin
                adc_d   = DATA_W'(acc_q >> kq_q);
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                err_d   = 1'b1;
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kq_q     <= '0;
            acc_q    <= '0;
            scnt_q   <= '0;
            tcnt_q   <= '0;
            rdy_q    <= 1'b1;
            adc_q    <= '0;
            err_q    <= 1'b0;
            drv_cs_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kq_q     <= kq_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            tcnt_q   <= tcnt_d;
            rdy_q    <= rdy_d;
            adc_q    <= adc_d;
            err_q    <= err_d;
            drv_cs_q <= drv_cs_d;
        end
    end

    assign rdy     = rdy_q;
    assign adc_out = adc_q;
    assign err     = err_q;
    assign drv_cs  = drv_cs_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Bench for adc_avg_sequencer: driver model plus a per-operation timeline model of rdy/adc_out/err/drv_cs.
module tb_adc_avg_sequencer;
    localparam int DATA_W = 14;
    localparam int SETTLE = 8;
    localparam int TO     = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs = 1'b0;
    logic [2:0]        avg_log2 = 3'd0;
    logic              rdy, err, drv_cs;
    logic [DATA_W-1:0] adc_out;
    logic              drv_rdy = 1'b1;
    logic [DATA_W-1:0] drv_data = '0;

    adc_avg_sequencer #(
        .DATA_W(DATA_W), .MAX_LOG2(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .avg_log2(avg_log2), .rdy(rdy),
        .adc_out(adc_out), .err(err), .drv_cs(drv_cs), .drv_rdy(drv_rdy), .drv_data(drv_data)
    );

    always #5 clk = ~clk;

    // d >= 2: drv_rdy low right after drv_cs, rises d negedges later (d cycles in WAIT);
    // d == 0: drv_rdy never drops; d < 0: drv_rdy drops and never rises.
    typedef struct { int d; logic [DATA_W-1:0] v; } job_t;
    typedef struct { longint at; logic r; logic [DATA_W-1:0] a; logic e; } ev_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     chk_en = 1'b0;
    ev_t    evq[$];
    longint cs_at[$];
    job_t   plan[$];
    job_t   jobs[$];
    job_t   cur;
    int     dcnt = 0;
    logic              exp_rdy = 1'b1, exp_err = 1'b0;
    logic [DATA_W-1:0] exp_adc = '0;
    logic [DATA_W-1:0] mdl_adc = '0;
    longint last_e0 = 0, last_rise = 0;
    logic   rdy_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    function automatic job_t mk(input int d, input logic [DATA_W-1:0] v);
        job_t j;
        j.d = d;
        j.v = v;
        return j;
    endfunction

    function automatic ev_t mkev(input longint at, input logic r, input logic [DATA_W-1:0] a, input logic e);
        ev_t x;
        x.at = at; x.r = r; x.a = a; x.e = e;
        return x;
    endfunction

    // Per-cycle compare against the timeline model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                exp_rdy = evq[0].r;
                exp_adc = evq[0].a;
                exp_err = evq[0].e;
                void'(evq.pop_front());
            end
            while (cs_at.size() > 0 && cs_at[0] < cyc) void'(cs_at.pop_front());
            if (chk_en) begin
                chk("rdy", 32'(rdy), 32'(exp_rdy));
                chk("adc_out", 32'(adc_out), 32'(exp_adc));
                chk("err", 32'(err), 32'(exp_err));
                chk("drv_cs", 32'(drv_cs), 32'(cs_at.size() > 0 && cs_at[0] == cyc));
            end
            if (!rdy_prev && rdy) last_rise = cyc;
            rdy_prev = rdy;
        end
    end

    // Advance to the next negedge and let the driver model react.
    task automatic tick();
        @(negedge clk);
        if (drv_cs === 1'b1) begin
            if (jobs.size() > 0) cur = jobs.pop_front();
            else cur = mk(2, '0);
            drv_data = DATA_W'($urandom);
            if (cur.d != 0) drv_rdy = 1'b0;
            dcnt = cur.d;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                drv_rdy  = 1'b1;
                drv_data = cur.v;
            end
        end
    endtask

    task automatic run_op(input int kin, input int x1, input int x2, input bit cs_done, input int rst_off);
        int k, n;
        longint e0, t, done, r_edge, stop;
        logic [17:0] sum;
        bit ab;
        logic [DATA_W-1:0] res;
        k = (kin > 4) ? 4 : kin;
        n = 1 << k;
        tick();
        avg_log2 = 3'(kin);
        cs = 1'b1;
        e0 = cyc + 1;
        t = e0 + SETTLE;
        sum = '0;
        ab = 1'b0;
        jobs = plan;
        for (int i = 0; i < n && !ab; i++) begin
            cs_at.push_back(t);
            if (plan[i].d == 0) begin
                t += 1 + TO; ab = 1'b1;
            end else if (plan[i].d < 0) begin
                t += 2 + TO; ab = 1'b1;
            end else begin
                sum += 18'(plan[i].v);
                t += longint'(plan[i].d + 2);
            end
        end
        done = t + 1;
        res = ab ? mdl_adc : DATA_W'(sum >> k);
        evq.push_back(mkev(e0, 1'b0, mdl_adc, 1'b0));
        evq.push_back(mkev(done, 1'b1, res, ab));
        mdl_adc = res;
        r_edge = (rst_off > 0) ? e0 + rst_off : 0;
        stop = cs_done ? done + 12 : done + 2;
        if (rst_off > 0) stop = r_edge + 2;
        last_e0 = e0;
        while (cyc < stop) begin
            tick();
            cs = (x1 > 0 && cyc + 1 == e0 + x1) || (x2 > 0 && cyc + 1 == e0 + x2) ||
                 (cs_done && cyc + 1 == done);
            avg_log2 = 3'($urandom_range(0, 7));
            rst = (r_edge != 0 && cyc + 1 == r_edge);
            if (rst) begin
                while (evq.size() > 0 && evq[$].at >= r_edge) void'(evq.pop_back());
                while (cs_at.size() > 0 && cs_at[$] >= r_edge) void'(cs_at.pop_back());
                evq.push_back(mkev(r_edge, 1'b1, '0, 1'b0));
                mdl_adc = '0;
                jobs.delete();
                dcnt = 0;
                drv_rdy = 1'b1;
            end
        end
        cs = 1'b0;
        rst = 1'b0;
        jobs.delete();
        dcnt = 0;
        drv_rdy = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int kin, n, abi, d;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_adc", 32'(adc_out), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Single sample, 11 cycles in the handshake.
        plan.delete();
        plan.push_back(mk(11, 14'h1ABC));
        run_op(0, 0, 0, 1'b0, 0);
        chk("t1_latency", 32'(last_rise - last_e0), 32'd22);
        chk("t1_adc", 32'(adc_out), 32'h1ABC);
        chk("t1_err", 32'(err), 32'd0);

        // Four samples, truncated mean.
        plan.delete();
        plan.push_back(mk(10, 14'd100));
        plan.push_back(mk(10, 14'd200));
        plan.push_back(mk(10, 14'd300));
        plan.push_back(mk(10, 14'd401));
        run_op(2, 0, 0, 1'b0, 0);
        chk("t2_adc", 32'(adc_out), 32'd250);

        // Clamped exponent, full-scale samples.
        plan.delete();
        for (int i = 0; i < 16; i++) plan.push_back(mk($urandom_range(2, 6), 14'h3FFF));
        run_op(7, 0, 0, 1'b0, 0);
        chk("t3_adc", 32'(adc_out), 32'h3FFF);

        // Driver never drops drv_rdy: abort, previous result retained.
        plan.delete();
        plan.push_back(mk(0, 14'h0));
        run_op(0, 0, 0, 1'b0, 0);
        chk("t4_latency", 32'(last_rise - last_e0), 32'd265);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_adc", 32'(adc_out), 32'h3FFF);

        // Stray cs in SETTLE, in WAIT_HI and on the DONE edge.
        plan.delete();
        plan.push_back(mk(10, 14'd100));
        plan.push_back(mk(10, 14'd200));
        plan.push_back(mk(10, 14'd300));
        plan.push_back(mk(10, 14'd401));
        run_op(2, 3, 14, 1'b1, 0);
        chk("t5_adc", 32'(adc_out), 32'd250);
        chk("t5_err", 32'(err), 32'd0);

        // Reset during WAIT_HI of the third sample, then a fresh single-sample run.
        plan.delete();
        for (int i = 0; i < 8; i++) plan.push_back(mk(10, DATA_W'($urandom)));
        run_op(3, 0, 0, 1'b0, 38);
        chk("t6_rst_rdy", 32'(rdy), 32'd1);
        chk("t6_rst_adc", 32'(adc_out), 32'd0);
        plan.delete();
        plan.push_back(mk(4, 14'd5));
        run_op(0, 0, 0, 1'b0, 0);
        chk("t6_adc", 32'(adc_out), 32'd5);

        // Randomized operations, some aborting in either wait phase.
        for (int r = 0; r < 30; r++) begin
            kin = $urandom_range(0, 7);
            n = 1 << ((kin > 4) ? 4 : kin);
            abi = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            plan.delete();
            for (int i = 0; i < n; i++) begin
                d = $urandom_range(2, 12);
                if (i == abi) d = ($urandom_range(0, 1) == 1) ? 0 : -1;
                plan.push_back(mk(d, DATA_W'($urandom)));
            end
            run_op(kin, 0, 0, ($urandom_range(0, 3) == 0), 0);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
